// File: rtl/munoc_rchannel_lane_buffer_pkg.sv
// Shared width and AXI size-code helpers for the R-channel lane buffer.
// Size codes follow AXI: 2 = 32b, 3 = 64b, 4 = 128b.
package munoc_rchannel_lane_buffer_pkg;

    // Width of one packed R beat: {tid, last, resp[1:0], data}.
    function automatic int bw_rchannel(input int bw_tid, input int bw_data);
        return bw_tid + 3 + bw_data;
    endfunction

    // Number of data bits addressed by an AXI size code.
    function automatic int size_bits(input int size);
        return 8 << size;
    endfunction

    function automatic logic size_legal(input int size, input int bw_data, input int bw_lane);
        return (size_bits(size) <= bw_data) && (size_bits(size) >= bw_lane);
    endfunction

endpackage

// File: rtl/munoc_sync_lane_fifo.sv
// Single-clock FIFO holding one lane (or the header) of the R-channel buffer.
// Wrap-bit pointers separate full from empty; occupancy is kept in a register.
module munoc_sync_lane_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstnn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wptr == rptr);
        full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        do_push = push && !full && !flush;
        do_pop  = pop && !empty && !flush;
        rdata   = mem[rptr[AW-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstnn || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers alone define
    // which entries are valid, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/munoc_rchannel_lane_buffer.sv
// AXI R-channel buffer: one FIFO per data lane plus a header FIFO, lane-masked
// writes, size-selected reads, synchronous flush and a sticky illegal-size flag.
module munoc_rchannel_lane_buffer
    import munoc_rchannel_lane_buffer_pkg::*;
#(
    parameter int  BW_TID   = 4,
    parameter int  BW_DATA  = 128,
    parameter int  BW_LANE  = 32,
    parameter int  DEPTH    = 4,
    parameter int  BW_SIZE  = 3,
    localparam int NUM_LANE = BW_DATA / BW_LANE,
    localparam int BW_R     = bw_rchannel(BW_TID, BW_DATA),
    localparam int BW_CNT   = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                flush,
    input  logic [NUM_LANE-1:0] wlane_mask,
    input  logic                wvalid,
    output logic                wready,
    input  logic [BW_R-1:0]     wdata,
    input  logic [BW_SIZE-1:0]  rsize,
    output logic                rvalid,
    input  logic                rready,
    output logic [BW_R-1:0]     rdata,
    output logic [BW_CNT-1:0]   hdr_count,
    output logic                size_err
);

    localparam int BW_HDR = BW_TID + 3;

    logic [NUM_LANE-1:0]             lane_full;
    logic [NUM_LANE-1:0]             lane_empty;
    logic [NUM_LANE-1:0]             lane_sel;
    logic [NUM_LANE-1:0]             lane_push;
    logic [NUM_LANE-1:0]             lane_pop;
    logic [NUM_LANE-1:0][BW_CNT-1:0] unused_lane_count;
    logic                            hdr_full;
    logic                            hdr_empty;
    logic [BW_HDR-1:0]               hdr_rdata;
    logic [BW_DATA-1:0]              data_rdata;
    logic                            rsize_legal;
    logic                            push;
    logic                            pop;

    always_comb begin
        rsize_legal = size_legal(int'(rsize), BW_DATA, BW_LANE);
        lane_sel    = '0;
        for (int i = 0; i < NUM_LANE; i++) begin
            lane_sel[i] = (i * BW_LANE) < size_bits(int'(rsize));
        end
    end

    // Ready/valid trees ignore the opposite side of the same cycle on purpose.
    always_comb begin
        wready    = !flush && !hdr_full && ((wlane_mask & lane_full) == '0);
        rvalid    = !flush && !hdr_empty && rsize_legal && ((lane_sel & lane_empty) == '0);
        push      = wvalid && wready;
        pop       = rvalid && rready;
        lane_push = {NUM_LANE{push}} & wlane_mask;
        lane_pop  = {NUM_LANE{pop}} & lane_sel;
    end

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            size_err <= 1'b0;
        end else if (!hdr_empty && !rsize_legal) begin
            size_err <= 1'b1;
        end
    end

    munoc_sync_lane_fifo #(
        .WIDTH (BW_HDR),
        .DEPTH (DEPTH)
    ) u_hdr_fifo (
        .clk   (clk),
        .rstnn (rstnn),
        .flush (flush),
        .push  (push),
        .wdata (wdata[BW_R-1:BW_DATA]),
        .pop   (pop),
        .rdata (hdr_rdata),
        .full  (hdr_full),
        .empty (hdr_empty),
        .count (hdr_count)
    );

    for (genvar i = 0; i < NUM_LANE; i++) begin : g_lane
        munoc_sync_lane_fifo #(
            .WIDTH (BW_LANE),
            .DEPTH (DEPTH)
        ) u_lane_fifo (
            .clk   (clk),
            .rstnn (rstnn),
            .flush (flush),
            .push  (lane_push[i]),
            .wdata (wdata[(i+1)*BW_LANE-1 -: BW_LANE]),
            .pop   (lane_pop[i]),
            .rdata (data_rdata[(i+1)*BW_LANE-1 -: BW_LANE]),
            .full  (lane_full[i]),
            .empty (lane_empty[i]),
            .count (unused_lane_count[i])
        );
    end

    assign rdata = {hdr_rdata, data_rdata};

endmodule

// File: tb/tb_munoc_rchannel_lane_buffer.sv
// Directed bench for munoc_rchannel_lane_buffer at default parameters
// (4 lanes of 32b, depth 4, 4-bit tid).
module tb_munoc_rchannel_lane_buffer;

    localparam int BW_R = 4 + 3 + 128;

    logic            clk = 1'b0;
    logic            rstnn;
    logic            flush;
    logic [3:0]      wlane_mask;
    logic            wvalid;
    logic            wready;
    logic [BW_R-1:0] wdata;
    logic [2:0]      rsize;
    logic            rvalid;
    logic            rready;
    logic [BW_R-1:0] rdata;
    logic [2:0]      hdr_count;
    logic            size_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [BW_R-1:0] beats [5];

    munoc_rchannel_lane_buffer dut (
        .clk        (clk),
        .rstnn      (rstnn),
        .flush      (flush),
        .wlane_mask (wlane_mask),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .rsize      (rsize),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .hdr_count  (hdr_count),
        .size_err   (size_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW_R-1:0] mk(input logic [3:0] tid, input logic last,
                                           input logic [1:0] resp, input logic [31:0] l3,
                                           input logic [31:0] l2, input logic [31:0] l1,
                                           input logic [31:0] l0);
        return {tid, last, resp, l3, l2, l1, l0};
    endfunction

    // Inputs change 1ns after the edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [BW_R-1:0] bp, bq, bh, bj, bl, bn;

    initial begin
        rstnn = 1'b0; flush = 1'b0; wlane_mask = 4'hF; wvalid = 1'b0;
        wdata = '0; rsize = 3'd4; rready = 1'b0;
        repeat (2) step();
        rstnn = 1'b1;
        settle();
        check("rst_wready", wready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_hdr_count", hdr_count, 0);
        check("rst_size_err", size_err, 0);

        // Single full-width beat, one-cycle latency, no bypass
        beats[0] = mk(4'd3, 1'b1, 2'd0, 32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000);
        wdata = beats[0]; wvalid = 1'b1;
        settle();
        check("t1_wready", wready, 1);
        check("t1_no_bypass", rvalid, 0);
        step();
        wvalid = 1'b0;
        settle();
        check("t1_rvalid", rvalid, 1);
        check("t1_count1", hdr_count, 1);
        check("t1_rdata", rdata, beats[0]);
        rready = 1'b1;
        step();
        rready = 1'b0;
        settle();
        check("t1_count0", hdr_count, 0);
        check("t1_rvalid_after", rvalid, 0);

        // Fill to DEPTH, then a pop and a write in the same cycle
        for (int k = 0; k < 5; k++) begin
            beats[k] = mk(4'(k + 8), k[0], 2'(k), 32'(k * 4 + 3), 32'(k * 4 + 2),
                          32'(k * 4 + 1), 32'(k * 4));
        end
        for (int k = 0; k < 4; k++) begin
            wdata = beats[k]; wvalid = 1'b1;
            settle();
            check("t2_fill_wready", wready, 1);
            step();
        end
        wvalid = 1'b0;
        settle();
        check("t2_full_wready", wready, 0);
        check("t2_full_count", hdr_count, 4);
        rready = 1'b1; wvalid = 1'b1; wdata = beats[4];
        settle();
        check("t2_popwrite_wready", wready, 0);
        check("t2_head", rdata, beats[0]);
        step();
        rready = 1'b0;
        settle();
        check("t2_count3", hdr_count, 3);
        check("t2_retry_wready", wready, 1);
        step();
        wvalid = 1'b0;
        settle();
        check("t2_count4", hdr_count, 4);
        for (int k = 1; k < 5; k++) begin
            rready = 1'b1;
            settle();
            check("t2_drain", rdata, beats[k]);
            step();
        end
        rready = 1'b0;
        settle();
        check("t2_drained", hdr_count, 0);

        // 32b read pops only lane0; lanes 1-3 retain their entries
        bp = mk(4'd5, 1'b0, 2'd1, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000);
        bq = mk(4'd6, 1'b1, 2'd2, 32'hBAD0_0003, 32'hBAD0_0002, 32'hBAD0_0001, 32'h6666_0000);
        wdata = bp; wlane_mask = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0; rsize = 3'd2;
        settle();
        check("t3_rvalid32", rvalid, 1);
        check("t3_hdr32", rdata[BW_R-1:128], bp[BW_R-1:128]);
        check("t3_lane0", rdata[31:0], 32'h5555_0000);
        rready = 1'b1;
        step();
        rready = 1'b0;
        wdata = bq; wlane_mask = 4'h1; wvalid = 1'b1;
        settle();
        check("t3_mask1_wready", wready, 1);
        step();
        wvalid = 1'b0; rsize = 3'd4;
        settle();
        check("t3_rvalid128", rvalid, 1);
        check("t3_skew_rdata", rdata,
              mk(4'd6, 1'b1, 2'd2, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h6666_0000));
        rready = 1'b1;
        step();
        rready = 1'b0;
        settle();
        check("t3_count0", hdr_count, 0);

        // Header present, lanes 2-3 empty
        bh = mk(4'd9, 1'b0, 2'd0, 32'hDEAD_0003, 32'hDEAD_0002, 32'h9999_0001, 32'h9999_0000);
        bj = mk(4'd10, 1'b1, 2'd3, 32'hAAAA_0003, 32'hAAAA_0002, 32'hDEAD_0001, 32'hDEAD_0000);
        wdata = bh; wlane_mask = 4'h3; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        settle();
        check("t4_rvalid128_wait", rvalid, 0);
        rsize = 3'd3;
        settle();
        check("t4_rvalid64", rvalid, 1);
        rsize = 3'd4; wdata = bj; wlane_mask = 4'hC; wvalid = 1'b1;
        settle();
        check("t4_not_landed", rvalid, 0);
        step();
        wvalid = 1'b0;
        settle();
        check("t4_rvalid_landed", rvalid, 1);
        check("t4_rdata",  rdata,
              mk(4'd9, 1'b0, 2'd0, 32'hAAAA_0003, 32'hAAAA_0002, 32'h9999_0001, 32'h9999_0000));
        rready = 1'b1;
        step();
        rready = 1'b0;
        settle();
        check("t4_count1", hdr_count, 1);
        check("t4_orphan_hdr", rvalid, 0);

        // Illegal size (256b > BW_DATA) with a header queued
        rsize = 3'd5;
        settle();
        check("t5_rvalid", rvalid, 0);
        check("t5_err_before", size_err, 0);
        step();
        check("t5_err_set", size_err, 1);
        check("t5_count", hdr_count, 1);
        flush = 1'b1;
        settle();
        check("t5_flush_wready", wready, 0);
        step();
        flush = 1'b0; rsize = 3'd4;
        settle();
        check("t5_flush_count", hdr_count, 0);
        check("t5_err_sticky", size_err, 1);

        // Flush with 3 beats queued and a concurrent write
        wlane_mask = 4'hF;
        for (int k = 0; k < 3; k++) begin
            wdata = beats[k]; wvalid = 1'b1;
            step();
        end
        wvalid = 1'b0;
        settle();
        check("t6_count3", hdr_count, 3);
        flush = 1'b1; wvalid = 1'b1; wdata = beats[3];
        settle();
        check("t6_flush_wready", wready, 0);
        check("t6_flush_rvalid", rvalid, 0);
        step();
        flush = 1'b0; wvalid = 1'b0;
        settle();
        check("t6_count0", hdr_count, 0);
        check("t6_rvalid0", rvalid, 0);
        bl = mk(4'd12, 1'b1, 2'd1, 32'h1212_0003, 32'h1212_0002, 32'h1212_0001, 32'h1212_0000);
        wdata = bl; wvalid = 1'b1;
        settle();
        check("t6_post_wready", wready, 1);
        step();
        wvalid = 1'b0;
        settle();
        check("t6_post_rvalid", rvalid, 1);
        check("t6_post_rdata", rdata, bl);
        rready = 1'b1;
        step();
        rready = 1'b0;

        // Reset mid-transfer, then an undersized (16b) read code
        wdata = beats[4]; wvalid = 1'b1;
        step();
        wvalid = 1'b0; rstnn = 1'b0;
        step();
        rstnn = 1'b1;
        settle();
        check("t7_rst_count", hdr_count, 0);
        check("t7_rst_rvalid", rvalid, 0);
        check("t7_rst_err", size_err, 0);
        check("t7_rst_wready", wready, 1);
        bn = mk(4'd15, 1'b0, 2'd3, 32'hF0F0_0003, 32'hF0F0_0002, 32'hF0F0_0001, 32'hF0F0_0000);
        wdata = bn; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        settle();
        check("t7_rdata", rdata, bn);
        check("t7_rvalid", rvalid, 1);
        rsize = 3'd1;
        settle();
        check("t7_small_rvalid", rvalid, 0);
        step();
        check("t7_small_err", size_err, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
